// File: rtl/reg_file_mp_if.sv
// Register-file access bundle: two read ports, two writeback ports, issue strobe and pending mask.
interface reg_file_mp_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5
);
   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [ADDR_W-1:0] RS1;
   logic [ADDR_W-1:0] RS2;
   logic [DATA_W-1:0] RD1;
   logic [DATA_W-1:0] RD2;
   logic              Busy1;
   logic              Busy2;
   logic [ADDR_W-1:0] WAddrA;
   logic [DATA_W-1:0] WDataA;
   logic              RegWrA;
   logic [ADDR_W-1:0] WAddrB;
   logic [DATA_W-1:0] WDataB;
   logic              RegWrB;
   logic [ADDR_W-1:0] IssueRd;
   logic              IssueVld;
   logic [DEPTH-1:0]  PendMask;

   modport master (
      output RS1, RS2, WAddrA, WDataA, RegWrA, WAddrB, WDataB, RegWrB, IssueRd, IssueVld,
      input  RD1, RD2, Busy1, Busy2, PendMask
   );

   modport slave (
      input  RS1, RS2, WAddrA, WDataA, RegWrA, WAddrB, WDataB, RegWrB, IssueRd, IssueVld,
      output RD1, RD2, Busy1, Busy2, PendMask
   );
endinterface

// File: rtl/reg_file_mp.sv
// Two-write/two-read register file with write-through bypass and a per-register pending scoreboard.
module reg_file_mp #(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned ADDR_W  = 5,
   parameter bit          ZERO_R0 = 1'b1,
   parameter bit          BYPASS  = 1'b1
) (
   input  logic          Clk,
   input  logic          Reset,
   reg_file_mp_if.slave  bus
);
   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] regs_q [DEPTH];
   logic [DATA_W-1:0] regs_d [DEPTH];
   logic [DEPTH-1:0]  pend_q;
   logic [DEPTH-1:0]  pend_d;

   logic              wr_a_en_c;
   logic              wr_b_en_c;
   logic              iss_en_c;

   logic [ADDR_W-1:0] rs_c    [2];
   logic              hit_a_c [2];
   logic              hit_b_c [2];
   logic [DATA_W-1:0] rd_c    [2];
   logic              busy_c  [2];

   // Register 0 is hardwired when ZERO_R0, so its writes and issues are masked here once.
   always_comb begin
      wr_a_en_c = bus.RegWrA   && !(ZERO_R0 && (bus.WAddrA  == '0));
      wr_b_en_c = bus.RegWrB   && !(ZERO_R0 && (bus.WAddrB  == '0));
      iss_en_c  = bus.IssueVld && !(ZERO_R0 && (bus.IssueRd == '0));
   end

   always_comb begin
      regs_d = regs_q;
      if (wr_a_en_c) regs_d[bus.WAddrA] = bus.WDataA;
      if (wr_b_en_c) regs_d[bus.WAddrB] = bus.WDataB;
   end

   // Issue is applied last so a new producer outranks a same-cycle writeback.
   always_comb begin
      pend_d = pend_q;
      if (wr_a_en_c) pend_d[bus.WAddrA] = 1'b0;
      if (wr_b_en_c) pend_d[bus.WAddrB] = 1'b0;
      if (iss_en_c)  pend_d[bus.IssueRd] = 1'b1;
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         regs_q <= '{default: '0};
         pend_q <= '0;
      end else begin
         regs_q <= regs_d;
         pend_q <= pend_d;
      end
   end

   assign rs_c[0] = bus.RS1;
   assign rs_c[1] = bus.RS2;

   // Read operands and busy flags; B outranks A on the bypass path.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         hit_a_c[p] = wr_a_en_c && (bus.WAddrA == rs_c[p]);
         hit_b_c[p] = wr_b_en_c && (bus.WAddrB == rs_c[p]);
         rd_c[p]    = regs_q[rs_c[p]];
         busy_c[p]  = pend_q[rs_c[p]];
         if (ZERO_R0 && (rs_c[p] == '0)) begin
            rd_c[p] = '0;
         end else if (BYPASS && hit_b_c[p]) begin
            rd_c[p] = bus.WDataB;
         end else if (BYPASS && hit_a_c[p]) begin
            rd_c[p] = bus.WDataA;
         end
         if (BYPASS && (hit_a_c[p] || hit_b_c[p])) begin
            busy_c[p] = iss_en_c && (bus.IssueRd == rs_c[p]);
         end
      end
   end

   assign bus.RD1      = rd_c[0];
   assign bus.RD2      = rd_c[1];
   assign bus.Busy1    = busy_c[0];
   assign bus.Busy2    = busy_c[1];
   assign bus.PendMask = pend_q;
endmodule
